// File: rtl/disk_sd_sched.sv
// SD block-read scheduler for the Apple II disk subsystem: floppy track loader and HDD block reads share one hps_io channel.
// Optional watchdog abort is built when SD_TIMEOUT_EN is defined.
module disk_sd_sched #(
    parameter int SECTORS_PER_TRACK = 13,
    parameter int TRACK_W           = 6,
    parameter int HDD_SEC_W         = 16,
    parameter int TIMEOUT_CYCLES    = 1048576
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic [TRACK_W-1:0]   track,
    input  logic                 fdd_img_mounted,
    input  logic                 fdd_img_valid,
    input  logic                 hdd_req,
    input  logic [HDD_SEC_W-1:0] hdd_sector,
    output logic [31:0]          sd_lba,
    output logic [1:0]           sd_rd,
    input  logic                 sd_ack,
    output logic [3:0]           track_sec,
    output logic                 cpu_wait,
    output logic                 busy,
    output logic                 hdd_done,
    output logic                 timeout_err
);

    // state    | meaning
    // IDLE     | nothing in flight; arbitrates pending requests, HDD first
    // FDD_WAIT | floppy block requested, waiting for sd_ack to rise
    // FDD_XFER | floppy block transferring, waiting for sd_ack to fall
    // HDD_WAIT | HDD block requested, waiting for sd_ack to rise
    // HDD_XFER | HDD block transferring, waiting for sd_ack to fall
    typedef enum logic [2:0] {
        IDLE,
        FDD_WAIT,
        FDD_XFER,
        HDD_WAIT,
        HDD_XFER
    } state_t;

    localparam logic [3:0] LAST_SEC = 4'(SECTORS_PER_TRACK - 1);

    state_t               state, state_nxt;
    logic                 old_ack;
    logic                 ack_rise, ack_fall;
    logic [TRACK_W-1:0]   cur_track, cur_track_nxt;
    logic                 hdd_pend, mnt_pend;
    logic                 hdd_clr, mnt_clr;
    logic [HDD_SEC_W-1:0] hdd_lba;
    logic [31:0]          lba_nxt;
    logic [1:0]           rd_nxt;
    logic [3:0]           tsec_nxt;
    logic                 wait_nxt;
    logic                 done_nxt;
    logic [31:0]          trk_lba;

    assign ack_rise = sd_ack & ~old_ack;
    assign ack_fall = ~sd_ack & old_ack;
    assign trk_lba  = 32'(track) * 32'(SECTORS_PER_TRACK);
    assign busy     = (state != IDLE);

`ifdef SD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             timeout_nxt;

    // Down-counter reloads on any state change or ack edge; terminal count aborts.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt     <= TMO_LOAD;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= timeout_nxt;
            if (state == IDLE || state_nxt != state || ack_rise || ack_fall)
                tmo_cnt <= TMO_LOAD;
            else if (tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TMO_W'(1);
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        cur_track_nxt = cur_track;
        lba_nxt       = sd_lba;
        rd_nxt        = sd_rd;
        tsec_nxt      = track_sec;
        wait_nxt      = cpu_wait;
        done_nxt      = 1'b0;
        hdd_clr       = 1'b0;
        mnt_clr       = 1'b0;
`ifdef SD_TIMEOUT_EN
        timeout_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (hdd_pend) begin
                    lba_nxt   = 32'(hdd_lba);
                    rd_nxt    = 2'b10;
                    wait_nxt  = 1'b1;
                    state_nxt = HDD_WAIT;
                end else if (track != cur_track || mnt_pend) begin
                    cur_track_nxt = track;
                    mnt_clr       = 1'b1;
                    if (fdd_img_valid) begin
                        tsec_nxt  = 4'd0;
                        lba_nxt   = trk_lba;
                        rd_nxt    = 2'b01;
                        wait_nxt  = 1'b1;
                        state_nxt = FDD_WAIT;
                    end
                end
            end
            FDD_WAIT: begin
                if (ack_rise) begin
                    lba_nxt = sd_lba + 32'd1;
                    if (track_sec == LAST_SEC)
                        rd_nxt = 2'b00;
                    state_nxt = FDD_XFER;
                end
            end
            FDD_XFER: begin
                if (ack_fall) begin
                    tsec_nxt = track_sec + 4'd1;
                    if (sd_rd == 2'b00) begin
                        wait_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FDD_WAIT;
                    end
                end
            end
            HDD_WAIT: begin
                if (ack_rise) begin
                    rd_nxt    = 2'b00;
                    hdd_clr   = 1'b1;
                    state_nxt = HDD_XFER;
                end
            end
            HDD_XFER: begin
                if (ack_fall) begin
                    wait_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef SD_TIMEOUT_EN
        // Abort leaves cur_track on the failed track so the load is not retried.
        if (state != IDLE && tmo_cnt == '0) begin
            rd_nxt      = 2'b00;
            wait_nxt    = 1'b0;
            done_nxt    = 1'b0;
            hdd_clr     = 1'b1;
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            old_ack   <= 1'b0;
            cur_track <= '0;
            hdd_pend  <= 1'b0;
            mnt_pend  <= 1'b0;
            hdd_lba   <= '0;
            sd_lba    <= '0;
            sd_rd     <= 2'b00;
            track_sec <= 4'd0;
            cpu_wait  <= 1'b0;
            hdd_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            old_ack   <= sd_ack;
            cur_track <= cur_track_nxt;
            hdd_pend  <= hdd_req | (hdd_pend & ~hdd_clr);
            mnt_pend  <= fdd_img_mounted | (mnt_pend & ~mnt_clr);
            if (hdd_req)
                hdd_lba <= hdd_sector;
            sd_lba    <= lba_nxt;
            sd_rd     <= rd_nxt;
            track_sec <= tsec_nxt;
            cpu_wait  <= wait_nxt;
            hdd_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_disk_sd_sched.sv
// Directed bench for disk_sd_sched: floppy track loads, HDD reads, arbitration, deferral and async reset.
// The watchdog sequence is included when SD_TIMEOUT_EN is defined.
module tb_disk_sd_sched;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [5:0]  track;
    logic        fdd_img_mounted;
    logic        fdd_img_valid;
    logic        hdd_req;
    logic [15:0] hdd_sector;
    logic [31:0] sd_lba;
    logic [1:0]  sd_rd;
    logic        sd_ack;
    logic [3:0]  track_sec;
    logic        cpu_wait;
    logic        busy;
    logic        hdd_done;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    disk_sd_sched #(
        .SECTORS_PER_TRACK(13),
        .TRACK_W(6),
        .HDD_SEC_W(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .track(track),
        .fdd_img_mounted(fdd_img_mounted),
        .fdd_img_valid(fdd_img_valid),
        .hdd_req(hdd_req),
        .hdd_sector(hdd_sector),
        .sd_lba(sd_lba),
        .sd_rd(sd_rd),
        .sd_ack(sd_ack),
        .track_sec(track_sec),
        .cpu_wait(cpu_wait),
        .busy(busy),
        .hdd_done(hdd_done),
        .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Assumes a floppy load was just launched at sd_lba == base.
    task automatic fdd_track(input logic [31:0] base);
        for (int i = 0; i < 13; i++) begin
            sd_ack = 1'b1;
            step();
            chk("fdd_lba", sd_lba, base + 32'd1 + 32'(i));
            chk("fdd_rd", 32'(sd_rd), (i == 12) ? 32'd0 : 32'd1);
            step();
            step();
            chk("fdd_wait_hold", 32'(cpu_wait), 32'd1);
            sd_ack = 1'b0;
            step();
            chk("fdd_tsec", 32'(track_sec), 32'(i + 1));
            chk("fdd_wait", 32'(cpu_wait), (i == 12) ? 32'd0 : 32'd1);
        end
        chk("fdd_busy_end", 32'(busy), 32'd0);
    endtask

    // Assumes an HDD read was just launched.
    task automatic hdd_serve(input logic [31:0] exp_lba);
        chk("hdd_lba", sd_lba, exp_lba);
        chk("hdd_rd", 32'(sd_rd), 32'd2);
        chk("hdd_wait", 32'(cpu_wait), 32'd1);
        sd_ack = 1'b1;
        step();
        chk("hdd_rd_rise", 32'(sd_rd), 32'd0);
        chk("hdd_wait_rise", 32'(cpu_wait), 32'd1);
        step();
        sd_ack = 1'b0;
        step();
        chk("hdd_done", 32'(hdd_done), 32'd1);
        chk("hdd_wait_end", 32'(cpu_wait), 32'd0);
        chk("hdd_busy_end", 32'(busy), 32'd0);
        step();
        chk("hdd_done_pulse", 32'(hdd_done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset_n = 1'b0;
        track = '0;
        fdd_img_mounted = 1'b0;
        fdd_img_valid = 1'b0;
        hdd_req = 1'b0;
        hdd_sector = '0;
        sd_ack = 1'b0;
        step();
        step();
        chk("rst_lba", sd_lba, 32'd0);
        chk("rst_rd", 32'(sd_rd), 32'd0);
        chk("rst_tsec", 32'(track_sec), 32'd0);
        chk("rst_wait", 32'(cpu_wait), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(hdd_done), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        reset_n = 1'b1;
        step();
        step();
        chk("idle_no_load", 32'(busy), 32'd0);

        // track change with no image: cur_track follows, nothing launches
        track = 6'd3;
        step();
        step();
        chk("noimg_busy", 32'(busy), 32'd0);
        chk("noimg_rd", 32'(sd_rd), 32'd0);

        // mount track 3: lba 39..52
        fdd_img_valid = 1'b1;
        fdd_img_mounted = 1'b1;
        step();
        fdd_img_mounted = 1'b0;
        chk("mnt_pend_only", 32'(busy), 32'd0);
        step();
        chk("t3_lba", sd_lba, 32'd39);
        chk("t3_rd", 32'(sd_rd), 32'd1);
        chk("t3_wait", 32'(cpu_wait), 32'd1);
        chk("t3_tsec", 32'(track_sec), 32'd0);
        fdd_track(32'd39);
        step();
        chk("t3_no_reload", 32'(busy), 32'd0);
        chk("t3_tsec_hold", 32'(track_sec), 32'd13);

        // single HDD read
        hdd_sector = 16'h1234;
        hdd_req = 1'b1;
        step();
        hdd_req = 1'b0;
        hdd_sector = 16'h0000;
        chk("hdd_pend_only", 32'(busy), 32'd0);
        step();
        hdd_serve(32'h0000_1234);

        // HDD request during track 5 load waits for the track
        track = 6'd5;
        step();
        chk("t5_lba", sd_lba, 32'd65);
        hdd_sector = 16'h0ABC;
        hdd_req = 1'b1;
        step();
        hdd_req = 1'b0;
        hdd_sector = 16'h5555;
        fdd_track(32'd65);
        chk("t5_hdd_deferred", 32'(sd_rd), 32'd0);
        step();
        hdd_serve(32'h0000_0ABC);

        // 5 -> 6 -> 7 during a reload of track 5: only track 7 follows
        fdd_img_mounted = 1'b1;
        step();
        fdd_img_mounted = 1'b0;
        step();
        chk("re5_lba", sd_lba, 32'd65);
        track = 6'd6;
        step();
        step();
        chk("re5_ignore_trk", sd_lba, 32'd65);
        track = 6'd7;
        fdd_track(32'd65);
        step();
        chk("t7_lba", sd_lba, 32'd91);
        chk("t7_rd", 32'(sd_rd), 32'd1);
        fdd_track(32'd91);
        step();
        step();
        chk("t7_settle", 32'(busy), 32'd0);

        // mount with no image does nothing
        fdd_img_valid = 1'b0;
        fdd_img_mounted = 1'b1;
        step();
        fdd_img_mounted = 1'b0;
        step();
        step();
        chk("noimg_mnt_busy", 32'(busy), 32'd0);
        chk("noimg_mnt_rd", 32'(sd_rd), 32'd0);

        // HDD and mount together: HDD first, then track 7 load
        fdd_img_valid = 1'b1;
        hdd_sector = 16'h0042;
        hdd_req = 1'b1;
        fdd_img_mounted = 1'b1;
        step();
        hdd_req = 1'b0;
        fdd_img_mounted = 1'b0;
        step();
        hdd_serve(32'h0000_0042);
        chk("both_fdd_next", sd_lba, 32'd91);
        chk("both_fdd_rd", 32'(sd_rd), 32'd1);
        fdd_track(32'd91);

        // async reset mid FDD_XFER with ack still high
        track = 6'd0;
        step();
        chk("t0_lba", sd_lba, 32'd0);
        chk("t0_rd", 32'(sd_rd), 32'd1);
        sd_ack = 1'b1;
        step();
        chk("t0_lba_rise", sd_lba, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_lba", sd_lba, 32'd0);
        chk("arst_rd", 32'(sd_rd), 32'd0);
        chk("arst_wait", 32'(cpu_wait), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        step();
        reset_n = 1'b1;
        step();
        step();
        chk("arst_ack_ignored", 32'(busy), 32'd0);
        sd_ack = 1'b0;
        step();
        chk("arst_idle", 32'(sd_rd), 32'd0);

`ifdef SD_TIMEOUT_EN
        fdd_img_mounted = 1'b1;
        step();
        fdd_img_mounted = 1'b0;
        step();
        chk("tmo_launch", 32'(sd_rd), 32'd1);
        for (int i = 1; i < 64; i++) begin
            step();
            chk("tmo_early", 32'(timeout_err), 32'd0);
        end
        step();
        chk("tmo_err", 32'(timeout_err), 32'd1);
        chk("tmo_rd", 32'(sd_rd), 32'd0);
        chk("tmo_wait", 32'(cpu_wait), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd0);
        step();
        chk("tmo_pulse", 32'(timeout_err), 32'd0);
        chk("tmo_no_retry", 32'(busy), 32'd0);
        hdd_sector = 16'h0777;
        hdd_req = 1'b1;
        step();
        hdd_req = 1'b0;
        step();
        hdd_serve(32'h0000_0777);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disk_sd_sched.md
Name: disk_sd_sched

Overview:
- Sequences all SD-card block reads for the Apple II disk subsystem and arbitrates the single hps_io SD read channel between two requesters.
- Requester 1 is the floppy track loader: on a track change or image mount it reloads a full track of SECTORS_PER_TRACK 512-byte blocks.
- Requester 2 is the hard-disk controller: one 512-byte block per request.
- Sits in the emu top level between apple2_top (track, HDD request, CPU stall) and hps_io (sd_lba, sd_rd, sd_ack).

Parameters:
SECTORS_PER_TRACK, 13, SD blocks per floppy track (range 1..15).
TRACK_W, 6, width of the floppy track number.
HDD_SEC_W, 16, width of the HDD sector number.
TIMEOUT_CYCLES, 1048576, watchdog limit in clk_sys cycles (used only with SD_TIMEOUT_EN).

Ports:
clk_sys  in  1  system clock; all logic on the rising edge.
reset_n  in  1  asynchronous active-low reset.
track  in  TRACK_W  current floppy head track from the drive model.
fdd_img_mounted  in  1  one-cycle pulse when a floppy image is (re)mounted.
fdd_img_valid  in  1  floppy image size is non-zero.
hdd_req  in  1  one-cycle HDD read request pulse.
hdd_sector  in  HDD_SEC_W  HDD block number; sampled in the cycle hdd_req is high.
sd_lba  out  32  block address to hps_io.
sd_rd  out  2  read strobe: bit0 = floppy device, bit1 = HDD device.
sd_ack  in  1  hps_io transfer acknowledge, high for the duration of one block.
track_sec  out  4  sector index within the track being loaded; forms the upper RAM address bits.
cpu_wait  out  1  CPU stall request.
busy  out  1  high in any state other than IDLE.
hdd_done  out  1  one-cycle pulse when an HDD block has fully transferred.
timeout_err  out  1  one-cycle pulse on a watchdog abort.

Behaviour:
- Interface decisions: single clock domain clk_sys; reset_n is asynchronous and active-low.
- Reset values: all outputs 0; internal cur_track=0, hdd_pend=0, mnt_pend=0, hdd_lba=0; state=IDLE. No track load occurs after reset until track changes or a mount pulse arrives.
- Acknowledge edges: old_ack is a registered copy of sd_ack. ack_rise = sd_ack & ~old_ack; ack_fall = ~sd_ack & old_ack.
- Request latching (every cycle, any state):
  - hdd_req sets hdd_pend and latches hdd_lba = hdd_sector. A request while hdd_pend is already set overwrites hdd_lba.
  - fdd_img_mounted sets mnt_pend.
  - If a set and a clear of the same flag coincide, the set wins.
- States: IDLE, FDD_WAIT, FDD_XFER, HDD_WAIT, HDD_XFER.
- IDLE, HDD has priority:
  - If hdd_pend: sd_lba = {zero-extend, hdd_lba}; sd_rd = 2'b10; cpu_wait = 1; go to HDD_WAIT.
  - Else if (track != cur_track) or mnt_pend: cur_track = track; clear mnt_pend. If fdd_img_valid: track_sec = 0; sd_lba = SECTORS_PER_TRACK * track (32-bit, no overflow); sd_rd = 2'b01; cpu_wait = 1; go to FDD_WAIT. Otherwise stay in IDLE.
- FDD_WAIT: on ack_rise, sd_lba += 1; if track_sec == SECTORS_PER_TRACK-1 then sd_rd = 0; go to FDD_XFER.
- FDD_XFER: on ack_fall, track_sec += 1.
  - If sd_rd == 0: cpu_wait = 0; go to IDLE. track_sec ends at SECTORS_PER_TRACK (13) and holds that value.
  - Else go to FDD_WAIT.
- HDD_WAIT: on ack_rise, sd_rd = 0; clear hdd_pend; go to HDD_XFER.
- HDD_XFER: on ack_fall, cpu_wait = 0; hdd_done = 1 for one cycle; go to IDLE.
- Track changes and mounts during a floppy load are deferred: the current track finishes, then IDLE re-evaluates on the next cycle. No abort path exists except the watchdog.
- HDD requests during a floppy load wait until the whole track has loaded.
- cpu_wait is held continuously from load start until the final ack_fall. There is no release between sectors.
- Back-to-back: IDLE spends exactly one cycle before launching the next pending request.
- Asynchronous reset mid-transfer: outputs clear immediately; any ack still in flight is ignored, because the edge detector restarts with old_ack=0 and the state is IDLE.

Optional Feature:
- Macro: SD_TIMEOUT_EN.
- Enabled:
  - A counter clears on every state change and on every ack edge, and counts while not in IDLE.
  - When the counter reaches TIMEOUT_CYCLES: sd_rd = 0, cpu_wait = 0, timeout_err pulses for one cycle, hdd_pend is cleared, state goes to IDLE.
  - cur_track is left at the aborted track, so no automatic retry occurs.
- Disabled: no counter is built; timeout_err is tied to 0; the block waits indefinitely for sd_ack.

Test Plan:
- Mount pulse with fdd_img_valid=1, track=3 → sd_lba=39 and sd_rd=01. Model 13 ack pulses → sd_lba reads 40..52 after successive ack rises; sd_rd drops at the 13th rise; cpu_wait falls at the 13th fall; track_sec=13.
- hdd_req with sector 0x1234 in IDLE → sd_lba=0x00001234 and sd_rd=10 on the next cycle. Ack pulse → sd_rd=0 at the rise; hdd_done pulses one cycle after the fall; cpu_wait falls.
- hdd_req during track 5 load → no HDD strobe until track completes. Then 1 IDLE cycle, then sd_rd=10 with the latched sector.
- track 5→6→7 during a load → after completion, exactly one additional load with sd_lba=91 (track 7); no load of track 6.
- Mount with fdd_img_valid=0 → no sd_rd, busy stays 0. hdd_req and mount pulse in the same cycle → HDD is served first, floppy load follows.
- SD_TIMEOUT_EN with TIMEOUT_CYCLES=64 and no ack → timeout_err at cycle 64 after launch, sd_rd=0, cpu_wait=0; a later hdd_req is serviced normally. Also assert reset_n mid-FDD_XFER → all outputs 0 asynchronously.
